// File: rtl/alu_seq_ctrl.sv
// Purpose: switch-driven ALU sequencer; a debounced step button loads A, B and an opcode, then executes.
// Latency: step is seen 2 cycles after the button rises; EXEC registers the result 1 cycle after the opcode.
// Backpressure: none; presses in EXEC are dropped and a held button only advances once.
module alu_seq_ctrl #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         step,
  input  logic         chain,
  output logic [W-1:0] out,
  output logic [3:0]   flags,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW_F  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]     op_q, op_d, flags_q, flags_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic           fill1_q, fill1_d, fill2_q, fill2_d, armed_q, armed_d;
  logic           adv;

  logic [W-1:0]   alu_res;
  logic           alu_cf, alu_of;
  logic [W:0]     sum_ext, diff_ext;
  logic [SHW-1:0] sh, shc;

  // Button synchroniser and rising-edge detector. The fill pipeline marks when the
  // synchroniser holds real samples; edges are only armed once the button has been
  // seen low, so a button held through reset never advances on release.
  always_comb begin
    sync1_d = step;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill1_d = 1'b1;
    fill2_d = fill1_q;
    armed_d = armed_q | (fill2_q & ~sync2_q);
    adv     = sync2_q & ~prev_q & armed_q;
  end

  // ALU: add/sub via a widened adder; rotates use a shift by W-sh, which wraps to 0 for sh=0.
  always_comb begin
    sh       = b_q[SHW-1:0];
    shc      = -sh;
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    alu_res  = '0;
    alu_cf   = 1'b0;
    alu_of   = 1'b0;
    case (op_q)
      4'd0: begin
        alu_res = sum_ext[W-1:0];
        alu_cf  = sum_ext[W];
        alu_of  = (a_q[W-1] == b_q[W-1]) && (sum_ext[W-1] != a_q[W-1]);
      end
      4'd1: begin
        alu_res = diff_ext[W-1:0];
        alu_cf  = diff_ext[W];
        alu_of  = (a_q[W-1] != b_q[W-1]) && (diff_ext[W-1] != a_q[W-1]);
      end
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = ~a_q;
      4'd6:    alu_res = a_q << sh;
      4'd7:    alu_res = a_q >> sh;
      4'd8:    alu_res = $unsigned($signed(a_q) >>> sh);
      4'd9:    alu_res = (a_q << sh) | (a_q >> shc);
      4'd10:   alu_res = (a_q >> sh) | (a_q << shc);
      4'd11:   alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  // Sequencer next state: loads wait for a press, EXEC completes unconditionally.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      LOAD_A:  if (adv) begin a_d = sw; state_d = LOAD_B; end
      LOAD_B:  if (adv) begin b_d = sw; state_d = LOAD_OP; end
      LOAD_OP: if (adv) begin op_d = sw[3:0]; state_d = EXEC; end
      EXEC: begin
        result_d = alu_res;
        flags_d  = {alu_res[W-1], alu_of, (alu_res == '0), alu_cf};
        state_d  = SHOW_F;
      end
      SHOW_F: begin
        if (adv) begin
          if (chain) begin
            a_d     = result_q;
            state_d = LOAD_B;
          end else begin
            state_d = LOAD_A;
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // All state flops share one asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      fill1_q  <= 1'b0;
      fill2_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      fill1_q  <= fill1_d;
      fill2_q  <= fill2_d;
      armed_q  <= armed_d;
    end
  end

  // Display mux: each load state shows what was just captured; SHOW_F can flip to the flags.
  always_comb begin
    out = sw;
    case (state_q)
      LOAD_A:  out = sw;
      LOAD_B:  out = a_q;
      LOAD_OP: out = b_q;
      EXEC:    out = result_q;
      SHOW_F:  out = sw[0] ? {{(W-4){1'b0}}, flags_q} : result_q;
      default: out = sw;
    endcase
  end

  assign flags = flags_q;
  assign state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: drives button presses, keeps expected ALU results in a queue
// and compares them as each operation reaches SHOW_F.
module tb_alu_seq_ctrl;
  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic         step;
  logic         chain;
  logic [W-1:0] out;
  logic [3:0]   flags;
  logic [2:0]   state;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  alu_seq_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .step  (step),
    .chain (chain),
    .out   (out),
    .flags (flags),
    .state (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU: {SF,OF,ZF,CF,result}; shifts and rotates done one bit at a time.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    logic [15:0] r;
    logic        cf, of;
    int          s, sa, sb, sh;
    r = '0; cf = 1'b0; of = 1'b0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    s  = 0;
    case (op)
      4'd0: begin
        s  = int'(a) + int'(b);
        r  = s[15:0];
        cf = s[16];
        of = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd1: begin
        s  = int'(a) - int'(b);
        r  = s[15:0];
        cf = (a < b);
        of = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a; for (int i = 0; i < sh; i++) r = {r[14:0], 1'b0}; end
      4'd7: begin r = a; for (int i = 0; i < sh; i++) r = {1'b0, r[15:1]}; end
      4'd8: begin r = a; for (int i = 0; i < sh; i++) r = {r[15], r[15:1]}; end
      4'd9: begin r = a; for (int i = 0; i < sh; i++) r = {r[14:0], r[15]}; end
      4'd10: begin r = a; for (int i = 0; i < sh; i++) r = {r[0], r[15:1]}; end
      4'd11: r = b;
      default: r = '0;
    endcase
    return {r[15], of, (r == 16'h0000), cf, r};
  endfunction

  // Press the button for 'hi' cycles and give the synchroniser time to act.
  task automatic press(input int hi);
    @(negedge clk);
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] target, input string tag);
    int n = 0;
    while (state !== target && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(target));
  endtask

  // Runs one operation up to SHOW_F and checks the result against the queue head.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input bit from_b);
    logic [19:0] e;
    if (!from_b) begin
      sw = a;
      @(negedge clk);
      chk("load_a_out_sw", 32'(out), 32'(a));
      press(1);
      wait_state(3'd1, "to_load_b");
    end
    chk("load_b_out_a", 32'(out), 32'(a));
    sw = b;
    press(1);
    wait_state(3'd2, "to_load_op");
    chk("load_op_out_b", 32'(out), 32'(b));
    sw = {12'h000, op};
    exp_q.push_back(model(a, b, op));
    press(1);
    sw = '0;
    wait_state(3'd4, "to_show_f");
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk("result", 32'(out), 32'(e[15:0]));
      chk("flags", 32'(flags), 32'(e[19:16]));
      sw = 16'h0001;
      @(negedge clk);
      chk("flag_view", 32'(out), {28'h0, e[19:16]});
      sw = '0;
    end
  endtask

  task automatic leave(input bit ch, input logic [2:0] nxt);
    chain = ch;
    press(1);
    wait_state(nxt, "leave_show_f");
    chain = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    step  = 1'b0;
    chain = 1'b0;
    sw    = 16'hA5A5;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_out_sw", 32'(out), 32'h0000A5A5);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Signed overflow on ADD, then both SUB cases.
    do_op(16'h7FFF, 16'h0001, 4'd0, 1'b0);
    chk("add_ovf_flags_const", 32'(flags), 32'h0000000C);
    leave(1'b0, 3'd0);
    do_op(16'h0003, 16'h0005, 4'd1, 1'b0);
    leave(1'b0, 3'd0);
    do_op(16'h0005, 16'h0005, 4'd1, 1'b0);
    leave(1'b0, 3'd0);

    // Arithmetic shift, rotate right, and an unused opcode.
    do_op(16'h8001, 16'h0001, 4'd8, 1'b0);
    leave(1'b0, 3'd0);
    do_op(16'h8001, 16'h0001, 4'd10, 1'b0);
    leave(1'b0, 3'd0);
    do_op(16'h1234, 16'h5678, 4'd13, 1'b0);
    leave(1'b0, 3'd0);

    // Rotates and shifts by zero return A.
    do_op(16'hBEEF, 16'h0010, 4'd9, 1'b0);
    leave(1'b0, 3'd0);

    // Accumulator mode: the sum becomes the next A.
    do_op(16'h0010, 16'h0020, 4'd0, 1'b0);
    leave(1'b1, 3'd1);
    chk("chain_a", 32'(out), 32'h00000030);
    do_op(16'h0030, 16'h0001, 4'd6, 1'b1);
    leave(1'b0, 3'd0);

    // Every opcode with random operands.
    for (int i = 0; i < 16; i++) begin
      do_op(16'($urandom), 16'($urandom), i[3:0], 1'b0);
      leave(1'b0, 3'd0);
    end

    // Long hold advances once; then reset in LOAD_OP with stale flags.
    do_op(16'h0003, 16'h0005, 4'd1, 1'b0);
    leave(1'b0, 3'd0);
    sw = 16'h0003;
    press(50);
    wait_state(3'd1, "hold_one_adv");
    repeat (10) @(negedge clk);
    chk("hold_stays_load_b", 32'(state), 32'd1);
    sw = 16'h0005;
    press(1);
    wait_state(3'd2, "pre_rst_load_op");
    chk("pre_rst_flags", 32'(flags), 32'h00000009);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    chk("mid_rst_out_sw", 32'(out), 32'(sw));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    do_op(16'h00FF, 16'h0F0F, 4'd4, 1'b0);
    leave(1'b0, 3'd0);

    // Sub-cycle glitch between clock edges.
    @(negedge clk);
    #1 step = 1'b1;
    #2 step = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_at_most_one", 32'(state <= 3'd1), 32'd1);

    // Button held through reset release must not advance.
    @(negedge clk);
    rst  = 1'b0;
    step = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_adv_after_rst", 32'(state), 32'd0);
    step = 1'b0;
    repeat (5) @(negedge clk);
    sw = 16'h0042;
    press(1);
    wait_state(3'd1, "repress_adv");
    chk("repress_a", 32'(out), 32'h00000042);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter W: default 16; datapath width, legal values 8, 16 and 32.
REQ-002 SHALL have parameter SHW: default $clog2(W); number of shift-amount bits taken from B.
REQ-003 SHALL have port clk: input, 1 bit; system clock, rising edge.
REQ-004 SHALL have port rst: input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port sw: input, W bits; switch operand/opcode source, sampled on step.
REQ-006 SHALL have port step: input, 1 bit; raw asynchronous advance button, high = pressed.
REQ-007 SHALL have port chain: input, 1 bit; 1 = accumulator mode, 0 = independent operations.
REQ-008 SHALL have port out: output, W bits; display value.
REQ-009 SHALL have port flags: output, 4 bits; {SF,OF,ZF,CF} of the last EXEC.
REQ-010 SHALL have port state: output, 3 bits; current FSM state code.

Function
REQ-011 SHALL synchronise step through 2 flops, then produce a 1-cycle pulse adv on the sync 0->1 transition; adv fires exactly once per press regardless of hold length.
REQ-012 SHALL implement FSM codes LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW_F=4; codes 5-7 SHALL go to LOAD_A on the next clock.
REQ-013 SHALL, on adv in LOAD_A, latch A<=sw and go to LOAD_B; on adv in LOAD_B, latch B<=sw and go to LOAD_OP; on adv in LOAD_OP, latch op<=sw[3:0] and go to EXEC.
REQ-014 SHALL, in EXEC, without waiting for adv, register result and flags in one cycle and go to SHOW_F.
REQ-015 SHALL, on adv in SHOW_F, go to LOAD_A when chain=0; when chain=1, SHALL load A<=result and go to LOAD_B.
REQ-016 SHALL, with no adv in a LOAD_* or SHOW_F state, hold state and all registers.
REQ-017 SHALL select out by state: LOAD_A shows sw; LOAD_B shows A; LOAD_OP shows B; EXEC and SHOW_F show result, except SHOW_F with sw[0]=1 shows {W-4 zeros, flags}.
REQ-018 SHALL support these ops: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SLL A<<B[SHW-1:0]; 7 SRL; 8 SRA; 9 ROL; 10 ROR; 11 pass B; 12-15 result 0.
REQ-019 SHALL compute every result modulo 2^W.
REQ-020 SHALL set CF as follows: ADD carry-out of bit W-1; SUB unsigned borrow (A<B); all other ops 0.
REQ-021 SHALL set OF to signed overflow for ADD and SUB and to 0 for all other ops.
REQ-022 SHALL set ZF = (result==0) and SF = result[W-1] for all ops.
REQ-023 SHALL give shift/rotate by amount 0 the result A.
REQ-024 SHALL ignore adv arriving on the EXEC cycle; it is not queued.

Reset
REQ-025 SHALL, on rst low (at any time, including mid-sequence), immediately force state=LOAD_A and A, B, op, result, flags and the synchroniser/edge flops to 0.
REQ-026 SHALL hold out = sw (LOAD_A behaviour) while in reset.
REQ-027 SHALL NOT generate adv on release of rst when step is already held high; the press must be released and pressed again.

Verification
REQ-028 SHALL cover W=16, chain=0, A=0x7FFF, B=0x0001, op=0 -> result 0x8000, flags 4'b1100; SHOW_F with sw[0]=1 gives out=0x000C.
REQ-029 SHALL cover SUB A=0x0003, B=0x0005 -> result 0xFFFE, flags 4'b1001; SUB A=B=0x0005 -> result 0x0000, flags 4'b0010.
REQ-030 SHALL cover chain=1: ADD 0x0010+0x0020, then advance from SHOW_F -> state=LOAD_B and A=0x0030; then B=0x0001, op=6 -> result 0x0060.
REQ-031 SHALL cover step held high for 50 cycles in LOAD_A -> exactly one transition to LOAD_B; a 1-cycle glitch shorter than the synchroniser still yields at most one advance.
REQ-032 SHALL cover rst asserted in LOAD_OP after A and B are loaded -> state=0, flags=0, result=0 the same cycle; the next full sequence operates normally.
REQ-033 SHALL cover ops 8 and 10 with A=0x8001, B=0x0001 -> SRA gives 0xC000, ROR gives 0xC000; op 13 gives 0x0000 with ZF=1.
